// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Groups the fetch stage's pipeline-control, instruction-memory and IF/ID
// signals into one bundle. Clock and reset are not part of the bundle.
//
// Signals (direction as seen from the fetch stage, modport master):
//   stall         in   hazard unit: hold PC and IF/ID
//   flush         in   kill the IF/ID contents this cycle
//   branch_taken  in   EX-stage branch redirect
//   branch_target in   branch destination
//   jump          in   ID-stage jump redirect
//   jump_target   in   jump destination
//   imem_pc       out  byte address to instruction memory
//   imem_instr    in   instruction word returned for imem_pc
//   ifid_instr    out  latched instruction
//   ifid_pc       out  address of the latched instruction
//   ifid_pc4      out  ifid_pc + 4
//   ifid_valid    out  IF/ID holds a real instruction
//   fetch_fault   out  sticky illegal-fetch flag
//   fault_pc      out  first faulting PC
//   fetch_count   out  number of valid instructions loaded into IF/ID
// The slave modport is the surrounding pipeline / memory view.
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, branch_taken, branch_target, jump, jump_target,
        input  imem_instr,
        output imem_pc, ifid_instr, ifid_pc, ifid_pc4, ifid_valid,
        output fetch_fault, fault_pc, fetch_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, jump, jump_target,
        output imem_instr,
        input  imem_pc, ifid_instr, ifid_pc, ifid_pc4, ifid_valid,
        input  fetch_fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage. Owns the program counter, presents it to the
// instruction memory combinationally and latches the returned word into the
// IF/ID pipeline register. It handles stall, flush, branch/jump redirects and
// illegal fetch addresses (misaligned or past the end of memory).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (control inputs, memory port, IF/ID outputs)
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 60,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        illegal;
    logic        redirect;
    logic        load;

    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    // Fetch address decode: a redirect comes from an older instruction, so
    // it outranks both stall and an illegal current PC. An illegal PC halts
    // fetching until something redirects it.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        illegal  = (pc[1:0] != 2'b00) || (pc > LAST_PC);
        redirect = bus.branch_taken || bus.jump;
        load     = !redirect && !bus.flush && !bus.stall && !illegal;
        next_pc  = pc_plus4;
        if (bus.branch_taken)
            next_pc = bus.branch_target;
        else if (bus.jump)
            next_pc = bus.jump_target;
        else if (bus.stall || illegal)
            next_pc = pc;
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= next_pc;
    end

    // IF/ID register. A bubble keeps ifid_pc/ifid_pc4 unchanged and only
    // invalidates the slot; a stall without redirect or flush freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr <= NOP_WORD;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (redirect || bus.flush) begin
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
        end else if (bus.stall) begin
            ifid_instr <= ifid_instr;
        end else if (illegal) begin
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
        end else begin
            ifid_instr <= bus.imem_instr;
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
        end
    end

    // Sticky fault record: only the first illegal PC seen without a redirect
    // is kept; the flag clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault <= 1'b0;
            fault_pc    <= 32'd0;
        end else if (illegal && !redirect && !fetch_fault) begin
            fetch_fault <= 1'b1;
            fault_pc    <= pc;
        end
    end

    // Count of real instructions delivered into IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= 32'd0;
        else if (load)
            fetch_count <= fetch_count + 32'd1;
    end

    assign bus.imem_pc     = pc;
    assign bus.ifid_instr  = ifid_instr;
    assign bus.ifid_pc     = ifid_pc;
    assign bus.ifid_pc4    = ifid_pc4;
    assign bus.ifid_valid  = ifid_valid;
    assign bus.fetch_fault = fetch_fault;
    assign bus.fault_pc    = fault_pc;
    assign bus.fetch_count = fetch_count;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined datapath.
- Owns the program counter and drives the byte address into the instruction memory.
- Memory returns a 32-bit word combinationally from bytes pc..pc+3, big-endian byte order.
- Latches the returned word into the IF/ID pipeline register, with stall, flush, branch/jump redirect and fetch-fault handling.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- IMEM_BYTES, 60, instruction memory size in bytes; highest legal fetch address is IMEM_BYTES-4.
- NOP_WORD, 32'h0000_0000, word placed in ifid_instr for a bubble.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  kill the IF/ID contents this cycle.
- branch_taken  in  1  EX-stage branch redirect.
- branch_target  in  32  branch destination.
- jump  in  1  ID-stage jump redirect.
- jump_target  in  32  jump destination.
- imem_pc  out  32  byte address to instruction memory.
- imem_instr  in  32  instruction word returned for imem_pc.
- ifid_instr  out  32  latched instruction.
- ifid_pc  out  32  address of the latched instruction.
- ifid_pc4  out  32  ifid_pc+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky: illegal fetch address seen.
- fault_pc  out  32  first faulting PC.
- fetch_count  out  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC.
  - ifid_instr = NOP_WORD.
  - ifid_pc = 0, ifid_pc4 = 0, ifid_valid = 0.
  - fetch_fault = 0, fault_pc = 0, fetch_count = 0.
  - On release, the first fetch occurs at RESET_PC on the first rising edge.
- Address output: imem_pc = pc, combinational. There is no extra latency; the word for pc is sampled at the same edge that advances pc.
- Illegal address: illegal = (pc[1:0] != 0) or (pc > IMEM_BYTES-4). This is an unsigned compare.
- Next-PC priority, highest first:
  1. branch_taken -> branch_target.
  2. jump -> jump_target.
  3. stall -> hold.
  4. illegal -> hold (fetch halts).
  5. Otherwise pc+4, wrapping modulo 2^32.
- Redirect overrides stall: the redirect comes from an older instruction.
- IF/ID update per edge, highest priority first:
  1. flush, branch_taken or jump -> bubble: ifid_valid=0, ifid_instr=NOP_WORD; ifid_pc and ifid_pc4 hold.
  2. stall -> all IF/ID fields hold.
  3. illegal -> bubble.
  4. Otherwise load: ifid_instr=imem_instr, ifid_pc=pc, ifid_pc4=pc+4, ifid_valid=1.
- flush without a redirect discards the word currently being fetched. pc still follows the next-PC rules.
- Fault capture:
  - On the first edge where illegal is true and no redirect is present: fetch_fault<=1 and fault_pc<=pc.
  - Later faults do not update fault_pc.
  - fetch_fault clears only on reset.
  - A redirect to a legal address resumes fetching; fetch_fault stays 1.
- fetch_count increments by 1 on each load, wrapping at 2^32; it holds otherwise.
- Simultaneous branch_taken and jump: the branch wins. The jump is discarded and IF/ID is bubbled.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No partial IF/ID update survives.

Test Plan:
- Sequential fetch: reset, memory holds words at 0,4,8 -> imem_pc steps 0,4,8. ifid_instr shows each word one cycle later with ifid_valid=1. fetch_count=3 after 3 loads.
- Stall: at pc=8, assert stall for 2 cycles -> pc stays 8 and IF/ID holds word@4 with ifid_pc=4. After release, word@8 loads and fetch_count increments once.
- Branch during stall: pc=12, stall=1, branch_taken=1, branch_target=32 -> next pc=32 and IF/ID bubbled (ifid_valid=0, ifid_instr=0). Next cycle loads word@32.
- Branch vs jump: branch_target=20 and jump_target=40 asserted together -> pc=20 and one bubble.
- Fault: jump_target=58 -> pc=58, fetch_fault=1, fault_pc=58, pc holds, continuous bubbles. Then branch to 0 -> fetching resumes at 0 and fetch_fault stays 1.
- Async reset: assert rst_n=0 mid-cycle while pc=24 and ifid_valid=1 -> outputs go to reset values without waiting for a clk edge.
